// File: rtl/adder_array_pkg.sv
// Shared types and constants for the pipelined adder array: the lane opcode
// enum and signed-limit constant functions used by the optional ADDER_ARRAY_SAT_EN clamp.
package adder_array_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Largest positive two's-complement value of a w-bit word, 2^(w-1)-1
  function automatic logic [MAX_W-1:0] smax(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w - 1) v[i] = 1'b1;
    return v;
  endfunction

  // Most negative two's-complement value of a w-bit word, -2^(w-1)
  function automatic logic [MAX_W-1:0] smin(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i == w - 1) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/adder_lane.sv
// One lane: combinational ADD/SUB/ACC/CLR ALU with carry/overflow, optional
// signed saturation (ADDER_ARRAY_SAT_EN), and the lane accumulator register.
module adder_lane
  import adder_array_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_n1,
  input  logic [WIDTH-1:0] i_n2,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int M = WIDTH - 1;

`ifdef ADDER_ARRAY_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
`endif

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_a, w_b;
  logic [WIDTH:0]   w_sum, w_diff, w_ext;
  logic             w_ovf;

  // ACC reuses the adder with the accumulator as the first operand
  always_comb begin
    w_a    = (i_op == OP_ACC) ? r_acc : i_n1;
    w_b    = (i_op == OP_ACC) ? i_n1  : i_n2;
    w_sum  = {1'b0, w_a} + {1'b0, w_b};
    w_diff = {1'b0, w_a} - {1'b0, w_b};
    w_ext  = '0;
    w_ovf  = 1'b0;
    case (i_op)
      OP_ADD, OP_ACC: begin
        w_ext = w_sum;
        w_ovf = (w_a[M] == w_b[M]) && (w_sum[M] != w_a[M]);
      end
      OP_SUB: begin
        w_ext = w_diff;
        w_ovf = (w_a[M] != w_b[M]) && (w_diff[M] != w_a[M]);
      end
      default: begin
        w_ext = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  assign o_carry = w_ext[WIDTH];
  assign o_ovf   = w_ovf;

`ifdef ADDER_ARRAY_SAT_EN
  // On overflow the true result carries the sign of the first operand
  assign o_res = w_ovf ? (w_a[M] ? SMIN : SMAX) : w_ext[M:0];
`else
  assign o_res = w_ext[M:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      if (i_op == OP_ACC)      r_acc <= o_res;
      else if (i_op == OP_CLR) r_acc <= '0;
    end
  end

endmodule

// File: rtl/pipelined_adder_array.sv
// CHANNELS-lane, 2-stage valid/ready adder pipeline (S1 operands, S2 results).
// Define ADDER_ARRAY_SAT_EN to clamp overflowing lane results to the signed limits.
module pipelined_adder_array
  import adder_array_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                op,
  input  logic [CHANNELS*WIDTH-1:0] num1,
  input  logic [CHANNELS*WIDTH-1:0] num2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] res,
  output logic [CHANNELS-1:0]       carry,
  output logic [CHANNELS-1:0]       ovf,
  output logic                      busy
);

  localparam int STAGES = 2;

  logic                               r_live;
  logic [STAGES:1]                    r_vld_pipe;
  op_e                                r_s1_op;
  logic [CHANNELS-1:0][WIDTH-1:0]     r_s1_n1, r_s1_n2;
  logic [CHANNELS-1:0][WIDTH-1:0]     r_res;
  logic [CHANNELS-1:0]                r_carry, r_ovf;

  logic                               w_s2_load, w_s1_load;
  logic [CHANNELS-1:0][WIDTH-1:0]     w_res;
  logic [CHANNELS-1:0]                w_carry, w_ovf;

  assign w_s2_load = !r_vld_pipe[2] || out_ready;
  assign w_s1_load = r_vld_pipe[1] && w_s2_load;
  // r_live holds in_ready low until the first edge after reset release
  assign in_ready  = r_live && (!r_vld_pipe[1] || w_s2_load);

  assign out_valid = r_vld_pipe[2];
  assign busy      = |r_vld_pipe;
  assign res       = r_res;
  assign carry     = r_carry;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_vld_pipe <= '0;
      r_s1_op    <= OP_ADD;
      r_s1_n1    <= '0;
      r_s1_n2    <= '0;
      r_res      <= '0;
      r_carry    <= '0;
      r_ovf      <= '0;
    end else begin
      r_live <= 1'b1;
      if (in_ready) begin
        r_vld_pipe[1] <= in_valid;
        if (in_valid) begin
          r_s1_op <= op_e'(op);
          r_s1_n1 <= num1;
          r_s1_n2 <= num2;
        end
      end
      if (w_s2_load) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) begin
          r_res   <= w_res;
          r_carry <= w_carry;
          r_ovf   <= w_ovf;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    adder_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_op    (r_s1_op),
      .i_n1    (r_s1_n1[g]),
      .i_n2    (r_s1_n2[g]),
      .i_load  (w_s1_load),
      .o_res   (w_res[g]),
      .o_carry (w_carry[g]),
      .o_ovf   (w_ovf[g])
    );
  end

endmodule

// File: tb/tb_pipelined_adder_array.sv
// Directed-vector bench for pipelined_adder_array (W=8, CH=4); honours ADDER_ARRAY_SAT_EN.
module tb_pipelined_adder_array;
  import adder_array_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] num1 = '0, num2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic [3:0]  carry, ovf;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // stream scenario storage
  int          n_beats;
  logic [1:0]  b_op [16];
  logic [31:0] b_n1 [16], b_n2 [16];
  logic [31:0] g_res [16];
  logic [3:0]  g_carry [16];
  int          g_cyc [16];
  int          n_got, acc_at_release;
  logic        rdy_at_stall_end;

  pipelined_adder_array #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .num1(num1), .num2(num2), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .carry(carry), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; num1 = a; num2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Feeds b_* beats as accepted, holds out_ready low for [stall_from, stall_from+stall_len)
  task automatic run_stream(input int stall_from, input int stall_len);
    int bi;
    bi = 0; n_got = 0; acc_at_release = -1; rdy_at_stall_end = 1'bx;
    for (int cyc = 0; cyc < 60 && n_got < n_beats; cyc++) begin
      out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (cyc == stall_from + stall_len) acc_at_release = bi;
      in_valid = (bi < n_beats);
      if (bi < n_beats) begin
        op = b_op[bi]; num1 = b_n1[bi]; num2 = b_n2[bi];
      end
      #1;
      if (cyc == stall_from + stall_len - 1) rdy_at_stall_end = in_ready;
      if (in_valid && in_ready) bi++;
      if (out_valid && out_ready) begin
        g_res[n_got] = res; g_carry[n_got] = carry; g_cyc[n_got] = cyc;
        n_got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_valid_busy got=%b%b exp=00", out_valid, busy); end
    n_vec++; if (res !== 32'h0 || carry !== 4'h0 || ovf !== 4'h0) begin n_err++; $display("FAIL reset_outputs res=%h c=%h o=%h exp=0", res, carry, ovf); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(OP_ADD, 32'h0000_FF05, 32'h0000_0103);
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL add_lat1 valid=%b busy=%b exp=0,1", out_valid, busy); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_lat2 valid=%b exp=1", out_valid); end
    n_vec++; if (res !== 32'h0000_0008) begin n_err++; $display("FAIL add_res got=%h exp=00000008", res); end
    n_vec++; if (carry !== 4'b0010 || ovf !== 4'b0000) begin n_err++; $display("FAIL add_flags c=%b o=%b exp=0010,0000", carry, ovf); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain valid=%b exp=0", out_valid); end
  endtask

  task automatic test_sub();
    drive(OP_SUB, 32'h0000_8002, 32'h0000_0105);
    tick();
    n_vec++; if (out_valid !== 1'b1 || res !== 32'h0000_7FFD) begin n_err++; $display("FAIL sub_res v=%b got=%h exp=00007ffd", out_valid, res); end
    n_vec++; if (carry !== 4'b0001 || ovf !== 4'b0010) begin n_err++; $display("FAIL sub_flags c=%b o=%b exp=0001,0010", carry, ovf); end
    tick();
  endtask

  task automatic test_acc();
    n_beats = 4;
    for (int i = 0; i < 4; i++) begin
      b_op[i] = (i == 0) ? 2'(OP_CLR) : 2'(OP_ACC);
      b_n1[i] = 32'h1010_1010; b_n2[i] = 32'hFFFF_FFFF;
    end
    run_stream(100, 0);
    n_vec++; if (n_got !== 4) begin n_err++; $display("FAIL acc_count got=%0d exp=4", n_got); end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      n_vec++; if (g_res[i] !== 32'h1010_1010 * i) begin n_err++; $display("FAIL acc_res[%0d] got=%h exp=%h", i, g_res[i], 32'h1010_1010 * i); end
    end
    n_vec++; if (n_got == 4 && g_cyc[3] - g_cyc[1] !== 2) begin n_err++; $display("FAIL acc_b2b span got=%0d exp=2", g_cyc[3] - g_cyc[1]); end
    run_stream(2, 5);
    n_vec++; if (n_got !== 4) begin n_err++; $display("FAIL accstall_count got=%0d exp=4", n_got); end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      n_vec++; if (g_res[i] !== 32'h1010_1010 * i || g_carry[i] !== 4'h0) begin n_err++; $display("FAIL accstall_res[%0d] got=%h c=%h exp=%h c=0", i, g_res[i], g_carry[i], 32'h1010_1010 * i); end
    end
  endtask

  task automatic test_back_to_back();
    n_beats = 4;
    for (int i = 0; i < 4; i++) begin
      b_op[i] = OP_ADD; b_n1[i] = 32'h0101_0101 * (i + 1); b_n2[i] = 32'h2020_2020;
    end
    run_stream(0, 6);
    n_vec++; if (acc_at_release !== 2) begin n_err++; $display("FAIL bp_accepted got=%0d exp=2", acc_at_release); end
    n_vec++; if (rdy_at_stall_end !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b exp=0", rdy_at_stall_end); end
    n_vec++; if (n_got !== 4) begin n_err++; $display("FAIL bp_count got=%0d exp=4", n_got); end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      n_vec++; if (g_res[i] !== 32'h2121_2121 + 32'h0101_0101 * i || g_cyc[i] !== 6 + i) begin
        n_err++; $display("FAIL bp_beat[%0d] got=%h@%0d exp=%h@%0d", i, g_res[i], g_cyc[i], 32'h2121_2121 + 32'h0101_0101 * i, 6 + i);
      end
    end
  endtask

  task automatic test_sat();
    logic [31:0] exp_res;
`ifdef ADDER_ARRAY_SAT_EN
    exp_res = 32'h0000_007F;
`else
    exp_res = 32'h0000_0080;
`endif
    drive(OP_ADD, 32'h0000_007F, 32'h0000_0001);
    tick();
    n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL sat_res got=%h exp=%h", res, exp_res); end
    n_vec++; if (ovf !== 4'b0001 || carry !== 4'b0000) begin n_err++; $display("FAIL sat_flags o=%b c=%b exp=0001,0000", ovf, carry); end
    tick();
  endtask

  task automatic test_reset_inflight();
    logic seen;
    drive(OP_ACC, 32'h0505_0505, 32'h0);
    rst_n = 1'b0; #1;
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || res !== 32'h0) begin n_err++; $display("FAIL rst_inflight v=%b busy=%b res=%h exp=0,0,0", out_valid, busy, res); end
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (out_valid) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_ghost_output got=%b exp=0", seen); end
    drive(OP_ACC, 32'h0101_0101, 32'h0);
    tick();
    n_vec++; if (out_valid !== 1'b1 || res !== 32'h0101_0101) begin n_err++; $display("FAIL rst_acc_zero v=%b got=%h exp=01010101", out_valid, res); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_back_to_back();
    test_sat();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
